// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: register map, CTRL bit layout and
// the byte-enable merge helper used by the register file.
package pwm_pkg;

    // Channel geometry: each channel owns a 16-byte window, at most 8 channels.
    localparam int unsigned MaxCh    = 8;
    localparam int unsigned ChStride = 16;
    localparam int unsigned ChShift  = $clog2(ChStride);
    localparam int unsigned ChIdxW   = $clog2(MaxCh);

    // Per-channel register offsets within the channel window.
    localparam logic [ChShift-1:0] OffCtrl   = 4'h0;
    localparam logic [ChShift-1:0] OffDiv    = 4'h4;
    localparam logic [ChShift-1:0] OffPeriod = 4'h8;
    localparam logic [ChShift-1:0] OffDuty   = 4'hC;

    // Global registers.
    localparam logic [7:0] AddrIntrStatus = 8'h80;
    localparam logic [7:0] AddrIntrEnable = 8'h84;

    // CTRL bit indices; only the low three bits are implemented.
    localparam int unsigned CtrlEn  = 0;
    localparam int unsigned CtrlOe  = 1;
    localparam int unsigned CtrlPol = 2;
    localparam int unsigned CtrlW   = 3;

    // Replace only the byte lanes selected by be.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Simple register bus (read/write strobes, byte address, byte enables).
interface pwm_multi_if;

    logic        re;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;

    modport master (
        output re,
        output we,
        output addr,
        output wdata,
        output be,
        input  rdata
    );

    modport slave (
        input  re,
        input  we,
        input  addr,
        input  wdata,
        input  be,
        output rdata
    );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: clock-enable prescaler, period counter, active copies of
// period/duty reloaded at wrap (or continuously while disabled), output flop.
module pwm_channel #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             pol_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;
    logic             tick;
    logic             wrap;
    logic             raw;
    logic             load;

    // Prescaler tick, period wrap detection and raw compare.
    always_comb begin
        tick = en_i && (pcnt_q == div_i);
        // per_act == 0 parks the counter: no wrap, raw output low.
        wrap = tick && (per_act_q != '0) && (cnt_q >= (per_act_q - CNT_W'(1)));
        raw  = (per_act_q != '0) && (cnt_q < duty_act_q);
        load = !en_i || wrap;
    end

    // Next-state for prescaler, period counter, active copies and output.
    always_comb begin
        pcnt_d     = pcnt_q;
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;

        if (!en_i || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
        end

        if (!en_i) begin
            cnt_d = '0;
        end else if (tick) begin
            if (wrap || (per_act_q == '0)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // The pending value seen here is the pre-write one, so a bus write on
        // the wrap edge stays pending for a full period.
        if (load) begin
            per_act_d  = period_i;
            duty_act_d = duty_i;
        end

        pwm_d = (en_i & raw) ^ pol_i;
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q     <= '0;
            cnt_q      <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign wrap_o = wrap;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: register file with byte-enable writes,
// per-channel PWM engines, W1C interrupt status and combinational read mux.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pwm_multi_if.slave      bus_io,
    output logic [N_CH-1:0] pwm_o,
    output logic [N_CH-1:0] oe_o,
    output logic            intr_o
);

    logic [CtrlW-1:0] ctrl_q   [N_CH];
    logic [CtrlW-1:0] ctrl_d   [N_CH];
    logic [CNT_W-1:0] div_q    [N_CH];
    logic [CNT_W-1:0] div_d    [N_CH];
    logic [CNT_W-1:0] period_q [N_CH];
    logic [CNT_W-1:0] period_d [N_CH];
    logic [CNT_W-1:0] duty_q   [N_CH];
    logic [CNT_W-1:0] duty_d   [N_CH];

    logic [N_CH-1:0]  intr_status_q, intr_status_d;
    logic [N_CH-1:0]  intr_en_q, intr_en_d;
    logic [N_CH-1:0]  wrap;
    logic [N_CH-1:0]  w1c;

    logic             wr_en;
    logic             is_ch;
    logic [ChIdxW-1:0]  ch_sel;
    logic [ChShift-1:0] off;
    logic [31:0]      merged;
    logic [31:0]      rdata;

    // Address decode; a read strobe suppresses a simultaneous write.
    always_comb begin
        wr_en  = bus_io.we & ~bus_io.re;
        is_ch  = ~bus_io.addr[ChShift+ChIdxW];
        ch_sel = bus_io.addr[ChShift +: ChIdxW];
        off    = bus_io.addr[ChShift-1:0];
    end

    // Register-file next state with byte-enable merging and W1C handling.
    always_comb begin
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        period_d  = period_q;
        duty_d    = duty_q;
        intr_en_d = intr_en_q;
        w1c       = '0;
        merged    = '0;

        if (wr_en) begin
            if (is_ch) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_sel == ChIdxW'(c)) begin
                        case (off)
                            OffCtrl: begin
                                merged    = be_merge(32'(ctrl_q[c]), bus_io.wdata, bus_io.be);
                                ctrl_d[c] = merged[CtrlW-1:0];
                            end
                            OffDiv: begin
                                merged   = be_merge(32'(div_q[c]), bus_io.wdata, bus_io.be);
                                div_d[c] = merged[CNT_W-1:0];
                            end
                            OffPeriod: begin
                                merged      = be_merge(32'(period_q[c]), bus_io.wdata, bus_io.be);
                                period_d[c] = merged[CNT_W-1:0];
                            end
                            OffDuty: begin
                                merged    = be_merge(32'(duty_q[c]), bus_io.wdata, bus_io.be);
                                duty_d[c] = merged[CNT_W-1:0];
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (bus_io.addr == AddrIntrStatus) begin
                merged = be_merge(32'h0, bus_io.wdata, bus_io.be);
                w1c    = merged[N_CH-1:0];
            end else if (bus_io.addr == AddrIntrEnable) begin
                merged    = be_merge(32'(intr_en_q), bus_io.wdata, bus_io.be);
                intr_en_d = merged[N_CH-1:0];
            end
        end

        // A wrap in the same cycle as the clear keeps the bit set.
        intr_status_d = (intr_status_q & ~w1c) | wrap;
    end

    // Register file and interrupt state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                ctrl_q[c]   <= '0;
                div_q[c]    <= '0;
                period_q[c] <= '0;
                duty_q[c]   <= '0;
            end
            intr_status_q <= '0;
            intr_en_q     <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            div_q         <= div_d;
            period_q      <= period_d;
            duty_q        <= duty_d;
            intr_status_q <= intr_status_d;
            intr_en_q     <= intr_en_d;
        end
    end

    // Read mux; unmapped addresses and absent channels return zero.
    always_comb begin
        rdata = '0;
        if (is_ch) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_sel == ChIdxW'(c)) begin
                    case (off)
                        OffCtrl:   rdata = 32'(ctrl_q[c]);
                        OffDiv:    rdata = 32'(div_q[c]);
                        OffPeriod: rdata = 32'(period_q[c]);
                        OffDuty:   rdata = 32'(duty_q[c]);
                        default:   rdata = '0;
                    endcase
                end
            end
        end else if (bus_io.addr == AddrIntrStatus) begin
            rdata = 32'(intr_status_q);
        end else if (bus_io.addr == AddrIntrEnable) begin
            rdata = 32'(intr_en_q);
        end
    end

    assign bus_io.rdata = rdata;
    assign intr_o       = |(intr_status_q & intr_en_q);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (ctrl_q[c][CtrlEn]),
            .pol_i    (ctrl_q[c][CtrlPol]),
            .div_i    (div_q[c]),
            .period_i (period_q[c]),
            .duty_i   (duty_q[c]),
            .pwm_o    (pwm_o[c]),
            .wrap_o   (wrap[c])
        );

        assign oe_o[c] = ctrl_q[c][CtrlOe];
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus pushes expected values, a negedge
// monitor pops and compares against the selected DUT output.
module tb_pwm_multi;

    localparam int unsigned NCh  = 2;
    localparam int unsigned CntW = 16;

    localparam int KRdata = 0;
    localparam int KPwm   = 1;
    localparam int KOe    = 2;
    localparam int KIntr  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCh-1:0] pwm;
    logic [NCh-1:0] oe;
    logic           intr;

    pwm_multi_if bus ();

    pwm_multi #(
        .N_CH  (NCh),
        .CNT_W (CntW)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus),
        .pwm_o  (pwm),
        .oe_o   (oe),
        .intr_o (intr)
    );

    always #5 clk = ~clk;

    // Scoreboard queues.
    int          kind_q [$];
    int          ch_q   [$];
    logic [31:0] exp_q  [$];
    string       name_q [$];

    int   n_vec = 0;
    int   n_err = 0;
    logic chk_valid = 1'b0;

    int          m_kind;
    int          m_ch;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;

    int t_p;
    int t_duty;

    // Monitor: compares at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty: got check strobe required queued entry");
            end else begin
                m_kind = kind_q.pop_front();
                m_ch   = ch_q.pop_front();
                m_exp  = exp_q.pop_front();
                m_name = name_q.pop_front();
                case (m_kind)
                    KRdata:  m_act = bus.rdata;
                    KPwm:    m_act = {31'b0, pwm[m_ch]};
                    KOe:     m_act = {31'b0, oe[m_ch]};
                    default: m_act = {31'b0, intr};
                endcase
                if (m_act !== m_exp) begin
                    n_err++;
                    $display("FAIL %s @%0t: got %h required %h", m_name, $time, m_act, m_exp);
                end
            end
        end
    end

    function automatic logic [31:0] b2w(input bit x);
        return {31'b0, x};
    endfunction

    // Queue one expectation, let the monitor sample this cycle, move on a cycle.
    task automatic chk(input int kind, input int ch, input logic [31:0] e, input string nm);
        kind_q.push_back(kind);
        ch_q.push_back(ch);
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                          input logic with_re);
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        bus.we    = 1'b1;
        bus.re    = with_re;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus_wr(a, d, 4'hF, 1'b0);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] e, input string nm);
        bus.addr = a;
        bus.re   = 1'b1;
        chk(KRdata, 0, e, nm);
        bus.re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.re    = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.be    = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        chk(KPwm, 0, 0, "rst_pwm0");
        chk(KOe, 0, 0, "rst_oe0");
        chk(KIntr, 0, 0, "rst_intr");
        rst = 1'b0;
        rd_chk(8'h00, 0, "rst_ctrl0");
        rd_chk(8'h84, 0, "rst_intr_en");

        // 1: ch0 DIV 0, PERIOD 10, DUTY 3 -> 3 high, 7 low.
        wr(8'h04, 0);
        wr(8'h08, 10);
        wr(8'h0C, 3);
        wr(8'h00, 3);
        for (int k = 0; k < 23; k++) begin
            chk(KPwm, 0, b2w(k >= 1 && ((k - 1) % 10) < 3), "t1_pwm0");
        end
        chk(KOe, 0, 1, "t1_oe0");

        // 2: ch1 DIV 1, PERIOD 4, DUTY 2 -> 4 high, 4 low.
        wr(8'h14, 1);
        wr(8'h18, 4);
        wr(8'h1C, 2);
        wr(8'h10, 1);
        for (int k = 0; k < 18; k++) begin
            chk(KPwm, 1, b2w(k >= 1 && ((k - 1) % 8) < 4), "t2_pwm1");
        end
        chk(KOe, 1, 0, "t2_oe1");
        wr(8'h10, 0);
        wr(8'h10, 5);
        for (int k = 0; k < 18; k++) begin
            chk(KPwm, 1, b2w(k >= 1 && ((k - 1) % 8) >= 4), "t2_pwm1_inv");
        end
        wr(8'h10, 4);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(KPwm, 1, 1, "t2_pwm1_disabled_pol");
        end

        // 3: DUTY change mid-period and on the wrap edge.
        wr(8'h00, 0);
        wr(8'h0C, 3);
        wr(8'h00, 3);
        for (int k = 0; k < 43; k++) begin
            if (k == 4 || k == 19) begin
                bus.addr  = 8'h0C;
                bus.wdata = (k == 4) ? 32'd7 : 32'd2;
                bus.be    = 4'hF;
                bus.we    = 1'b1;
            end else if (k == 5 || k == 20) begin
                bus.we = 1'b0;
            end
            t_p    = k - 1;
            t_duty = (t_p / 10 == 0) ? 3 : ((t_p / 10 <= 2) ? 7 : 2);
            chk(KPwm, 0, b2w(k >= 1 && (t_p % 10) < t_duty), "t3_pwm0");
        end
        rd_chk(8'h0C, 2, "t3_duty_rd");

        // 4: edge duty/period values.
        wr(8'h00, 0);
        wr(8'h0C, 0);
        wr(8'h00, 3);
        for (int k = 0; k < 12; k++) begin
            chk(KPwm, 0, 0, "t4_duty0");
        end
        wr(8'h00, 0);
        wr(8'h0C, 12);
        wr(8'h00, 3);
        for (int k = 0; k < 25; k++) begin
            chk(KPwm, 0, b2w(k >= 1), "t4_duty_gt_period");
        end
        wr(8'h00, 0);
        wr(8'h08, 0);
        wr(8'h0C, 3);
        wr(8'h80, 32'hFF);
        wr(8'h00, 3);
        for (int k = 0; k < 20; k++) begin
            chk(KPwm, 0, 0, "t4_period0");
        end
        rd_chk(8'h80, 0, "t4_period0_no_intr");

        // 5: wrap interrupt, W1C, and W1C colliding with a wrap.
        wr(8'h00, 0);
        wr(8'h08, 5);
        wr(8'h0C, 2);
        wr(8'h84, 1);
        wr(8'h00, 3);
        for (int k = 0; k < 18; k++) begin
            if (k == 6 || k == 14) begin
                bus.addr  = 8'h80;
                bus.wdata = 32'd1;
                bus.be    = 4'hF;
                bus.we    = 1'b1;
            end else if (k == 7 || k == 15) begin
                bus.we = 1'b0;
            end
            chk(KIntr, 0, b2w(k >= 5 && !(k >= 7 && k <= 9)), "t5_intr");
        end
        rd_chk(8'h80, 1, "t5_status_kept");

        // 6: async reset mid-operation, byte enables, unmapped space, re+we.
        wr(8'h00, 0);
        wr(8'h08, 10);
        wr(8'h0C, 12);
        wr(8'h00, 3);
        repeat (12) @(posedge clk);
        #1;
        chk(KPwm, 0, 1, "t6_pwm0_pre_rst");
        chk(KIntr, 0, 1, "t6_intr_pre_rst");
        rst = 1'b1;
        chk(KPwm, 0, 0, "t6_pwm0_async_rst");
        chk(KOe, 0, 0, "t6_oe0_rst");
        chk(KIntr, 0, 0, "t6_intr_rst");
        rst = 1'b0;
        rd_chk(8'h00, 0, "t6_ctrl0_after_rst");
        rd_chk(8'h08, 0, "t6_period0_after_rst");
        chk(KPwm, 0, 0, "t6_pwm0_idle_after_rst");
        bus_wr(8'h08, 32'hFFFF_FFFF, 4'b0001, 1'b0);
        rd_chk(8'h08, 32'h0000_00FF, "t6_be_byte0");
        wr(8'h0C, 32'hFFFF_FFFF);
        rd_chk(8'h0C, 32'h0000_FFFF, "t6_duty_width");
        wr(8'h40, 32'h3);
        wr(8'h48, 32'h55);
        rd_chk(8'h40, 0, "t6_absent_ch_ctrl");
        rd_chk(8'h48, 0, "t6_absent_ch_period");
        bus_wr(8'h04, 32'h1234, 4'hF, 1'b1);
        rd_chk(8'h04, 0, "t6_re_we_no_write");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
